// File: rtl/message_scroller_pkg.sv
// Shared definitions for the message scroller run-mode display stage.
// Holds character code constants, the blank segment pattern, the FSM state
// type and small helpers for ring indexing and digit selection.
package message_scroller_pkg;

  localparam logic [6:0] CHAR_BLANK = 7'd63;
  localparam logic [6:0] CHAR_MAX   = 7'd62;
  localparam int         MSG_LEN    = 7;
  localparam int         RING_LEN   = 14;
  localparam logic [6:0] SEG_OFF    = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SCROLL,
    HOLD
  } state_t;

  // Ring position of digit d for a window starting at pos. The sum can reach
  // 13 + 6 = 19, so it is formed one bit wider before folding back by 14.
  function automatic logic [3:0] ring_idx(input logic [3:0] pos, input logic [2:0] digit);
    logic [4:0] sum;
    sum = {1'b0, pos} + {2'b00, digit};
    if (sum >= 5'(RING_LEN)) return 4'(sum - 5'(RING_LEN));
    else                     return sum[3:0];
  endfunction

  // Active-low one-hot select: digit d pulls bit 6-d low.
  function automatic logic [6:0] digit_sel(input logic [2:0] digit);
    return ~(7'b1000000 >> digit);
  endfunction

endpackage

// File: rtl/message_scroller_if.sv
// Display-side bundle of the message scroller.
//   mode        : 1 = setting (scroller idle), 0 = run
//   char0..6    : character codes, 0..62 valid, 63..127 blank
//   pause_btn   : single-cycle pulse toggling pause
//   trans       : active-low one-hot digit select
//   led7seg     : active-low segment pattern of the selected digit
//   scroll_pos  : current window start, 0..13
// master = the block feeding characters and reading the display,
// slave  = the scroller itself.
interface message_scroller_if;
  logic       mode;
  logic [6:0] char0, char1, char2, char3, char4, char5, char6;
  logic       pause_btn;
  logic [6:0] trans;
  logic [6:0] led7seg;
  logic [3:0] scroll_pos;

  modport master (
    output mode, char0, char1, char2, char3, char4, char5, char6, pause_btn,
    input  trans, led7seg, scroll_pos
  );

  modport slave (
    input  mode, char0, char1, char2, char3, char4, char5, char6, pause_btn,
    output trans, led7seg, scroll_pos
  );
endinterface

// File: rtl/message_scroller_table_char.sv
// table_char: registered character-code to 7-segment lookup (1-cycle latency).
//   clk  : clock
//   code : character code; 0..9 digits, 10..35 letters A..Z,
//          36..61 lowercase letters (drawn like 10..35), 62 dash
//   seg  : active-low pattern {g,f,e,d,c,b,a}; codes >= 63 give all off
module table_char
  import message_scroller_pkg::*;
(
  input  logic       clk,
  input  logic [6:0] code,
  output logic [6:0] seg
);

  logic [6:0] base;
  logic [6:0] pattern;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    base = code;
    if (code >= 7'd36 && code <= 7'd61) base = code - 7'd26;
  end

  always_comb begin
    pattern = SEG_OFF;
    case (base)
      7'd0:  pattern = 7'h40;  7'd1:  pattern = 7'h79;
      7'd2:  pattern = 7'h24;  7'd3:  pattern = 7'h30;
      7'd4:  pattern = 7'h19;  7'd5:  pattern = 7'h12;
      7'd6:  pattern = 7'h02;  7'd7:  pattern = 7'h78;
      7'd8:  pattern = 7'h00;  7'd9:  pattern = 7'h10;
      7'd10: pattern = 7'h08;  7'd11: pattern = 7'h03;
      7'd12: pattern = 7'h46;  7'd13: pattern = 7'h21;
      7'd14: pattern = 7'h06;  7'd15: pattern = 7'h0E;
      7'd16: pattern = 7'h42;  7'd17: pattern = 7'h09;
      7'd18: pattern = 7'h4F;  7'd19: pattern = 7'h61;
      7'd20: pattern = 7'h0A;  7'd21: pattern = 7'h47;
      7'd22: pattern = 7'h6A;  7'd23: pattern = 7'h2B;
      7'd24: pattern = 7'h23;  7'd25: pattern = 7'h0C;
      7'd26: pattern = 7'h18;  7'd27: pattern = 7'h2F;
      7'd28: pattern = 7'h12;  7'd29: pattern = 7'h07;
      7'd30: pattern = 7'h41;  7'd31: pattern = 7'h63;
      7'd32: pattern = 7'h55;  7'd33: pattern = 7'h09;
      7'd34: pattern = 7'h11;  7'd35: pattern = 7'h24;
      7'd62: pattern = 7'h3F;
      default: pattern = SEG_OFF;
    endcase
  end

  // NOTE: pure data pipeline register with no reset; whoever consumes it
  // masks it with a reset-cleared valid/blank flag.
  always_ff @(posedge clk) seg <= pattern;

endmodule

// File: rtl/message_scroller.sv
// message_scroller: run-mode stage that scrolls the seven edited characters
// right-to-left across a 7-digit multiplexed 7-segment display.
//   clk  : system clock
//   rst  : synchronous active-low reset
//   bus  : message_scroller_if.slave (mode, char0..6, pause_btn in;
//          trans, led7seg, scroll_pos out)
// Parameters: SCAN_DIV = scan counter terminal, STEP_DIV = step counter terminal.
// Build option: define MESSAGE_SCROLLER_PAUSE_EN to build the HOLD state and
// honour pause_btn; without it the pulse is ignored.
module message_scroller
  import message_scroller_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 25000,
  parameter int unsigned STEP_DIV = 12500000
) (
  input  logic              clk,
  input  logic              rst,
  message_scroller_if.slave bus
);

  localparam int SCAN_W = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
  localparam int STEP_W = (STEP_DIV > 0) ? $clog2(STEP_DIV + 1) : 1;

  state_t            state;
  logic [6:0]        msg [MSG_LEN];   // ring positions 0..6; 7..13 are always blank
  logic [SCAN_W-1:0] scan_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic [2:0]        digit;
  logic [6:0]        sel_d1;
  logic              blank_d1;
  logic [6:0]        seg_raw;
  logic [6:0]        cur_code;
  logic [3:0]        ring_i;
  logic              active;
  logic              scan_tick;
  logic              step_tick;
  logic [2:0]        next_digit;
  logic [3:0]        next_pos;
  logic              pause_hit;

`ifdef MESSAGE_SCROLLER_PAUSE_EN
  assign pause_hit = bus.pause_btn;
`else
  logic unused_pause;
  assign unused_pause = bus.pause_btn;
  assign pause_hit    = 1'b0;
`endif

  assign scan_tick  = (scan_cnt == SCAN_W'(SCAN_DIV));
  assign step_tick  = (step_cnt == STEP_W'(STEP_DIV));
  assign next_digit = (digit == 3'(MSG_LEN - 1)) ? 3'd0 : digit + 3'd1;
  assign next_pos   = (bus.scroll_pos == 4'(RING_LEN - 1)) ? 4'd0 : bus.scroll_pos + 4'd1;
  // Leaving run mode blanks the lookup stage at once so the display goes
  // dark within two edges of mode rising.
  assign active     = !bus.mode && (state != IDLE);
  assign ring_i     = ring_idx(bus.scroll_pos, digit);

  always_comb begin
    cur_code = CHAR_BLANK;
    // During LOAD the ring is still being written; the window starts at 0 and
    // the digit is 0, so char0 is fed straight through to save a cycle.
    if (state == LOAD)                cur_code = bus.char0;
    else if (ring_i < 4'(MSG_LEN))    cur_code = msg[ring_i[2:0]];
  end

  table_char u_table (
    .clk  (clk),
    .code (cur_code),
    .seg  (seg_raw)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      // NOTE: the message store is reset because its blank contents are
      // visible behaviour, unlike the lookup pipeline register.
      for (int i = 0; i < MSG_LEN; i++) msg[i] <= CHAR_BLANK;
      scan_cnt       <= '0;
      step_cnt       <= '0;
      digit          <= '0;
      sel_d1         <= SEG_OFF;
      blank_d1       <= 1'b1;
      bus.trans      <= SEG_OFF;
      bus.led7seg    <= SEG_OFF;
      bus.scroll_pos <= '0;
    end else begin
      // Select is delayed alongside the lookup so both change on the same edge.
      sel_d1      <= active ? digit_sel(digit) : SEG_OFF;
      blank_d1    <= !active || (cur_code > CHAR_MAX);
      bus.trans   <= sel_d1;
      bus.led7seg <= blank_d1 ? SEG_OFF : seg_raw;

      if (bus.mode) begin
        state    <= IDLE;
        scan_cnt <= '0;
        step_cnt <= '0;
        digit    <= '0;
      end else begin
        case (state)
          IDLE: begin
            scan_cnt <= '0;
            step_cnt <= '0;
            digit    <= '0;
            state    <= LOAD;
          end
          LOAD: begin
            msg[0] <= bus.char0;  msg[1] <= bus.char1;
            msg[2] <= bus.char2;  msg[3] <= bus.char3;
            msg[4] <= bus.char4;  msg[5] <= bus.char5;
            msg[6] <= bus.char6;
            bus.scroll_pos <= '0;
            scan_cnt       <= '0;
            step_cnt       <= '0;
            digit          <= '0;
            state          <= SCROLL;
          end
          SCROLL: begin
            scan_cnt <= scan_tick ? '0 : scan_cnt + SCAN_W'(1);
            if (scan_tick) digit <= next_digit;
            step_cnt <= step_tick ? '0 : step_cnt + STEP_W'(1);
            // A pause on the terminal cycle wins: the counter still clears
            // but the window does not move.
            if (pause_hit)      state          <= HOLD;
            else if (step_tick) bus.scroll_pos <= next_pos;
          end
`ifdef MESSAGE_SCROLLER_PAUSE_EN
          HOLD: begin
            scan_cnt <= scan_tick ? '0 : scan_cnt + SCAN_W'(1);
            if (scan_tick) digit <= next_digit;
            if (pause_hit) state <= SCROLL;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_message_scroller.sv
// Directed bench for message_scroller with SCAN_DIV=3, STEP_DIV=55.
module tb_message_scroller;
  localparam logic [6:0] OFF = 7'b1111111;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [6:0] exp_chars [7];

  message_scroller_if bus ();

  message_scroller #(.SCAN_DIV(3), .STEP_DIV(55)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [6:0] code);
    case (code)
      7'd10: return 7'h08;
      7'd11: return 7'h03;
      7'd12: return 7'h46;
      7'd13: return 7'h21;
      7'd14: return 7'h06;
      7'd15: return 7'h0E;
      7'd16: return 7'h42;
      7'd62: return 7'h3F;
      default: return (code > 7'd62) ? OFF : 7'bx;
    endcase
  endfunction

  function automatic logic [6:0] exp_code(input int pos, input int d);
    int i;
    i = (pos + d) % 14;
    return (i < 7) ? exp_chars[i] : 7'd63;
  endfunction

  function automatic logic [6:0] sel_of(input int d);
    logic [6:0] one;
    one = 7'b1000000;
    return ~(one >> d);
  endfunction

  function automatic int digit_of(input logic [6:0] t);
    for (int d = 0; d < 7; d++) if (t === sel_of(d)) return d;
    return 7;
  endfunction

  task automatic set_chars();
    bus.char0 = exp_chars[0]; bus.char1 = exp_chars[1];
    bus.char2 = exp_chars[2]; bus.char3 = exp_chars[3];
    bus.char4 = exp_chars[4]; bus.char5 = exp_chars[5];
    bus.char6 = exp_chars[6];
  endtask

  // Waits (bounded) for scroll_pos to change; returns at the following negedge.
  task automatic wait_change(output logic [3:0] p);
    logic [3:0] old;
    int n;
    old = bus.scroll_pos;
    n = 0;
    while (bus.scroll_pos === old && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("step_timeout", {31'b0, n < 100}, 32'd1);
    p = bus.scroll_pos;
  endtask

  // Checks every digit seen over 28 cycles against the model for window pos.
  task automatic check_window(input int pos);
    int d;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      d = digit_of(bus.trans);
      check("win_sel_valid", {31'b0, d != 7}, 32'd1);
      if (d != 7) check($sformatf("win_seg_p%0d_d%0d", pos, d), {25'b0, bus.led7seg},
                        {25'b0, exp_seg(exp_code(pos, d))});
    end
  endtask

  initial begin
    logic [3:0] p;
    logic [3:0] old;
    int changes;
    int n;

    for (int i = 0; i < 7; i++) exp_chars[i] = 7'(10 + i);
    set_chars();
    bus.mode      = 1'b0;
    bus.pause_btn = 1'b0;
    rst           = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_trans", {25'b0, bus.trans}, {25'b0, OFF});
    check("rst_seg",   {25'b0, bus.led7seg}, {25'b0, OFF});
    check("rst_pos",   {28'b0, bus.scroll_pos}, 32'd0);

    // Release: LOAD, lookup, output register -> lit on the third edge
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("latency_early", {25'b0, bus.trans}, {25'b0, OFF});
    @(negedge clk);
    check("first_trans", {25'b0, bus.trans}, {25'b0, 7'b0111111});
    check("first_seg",   {25'b0, bus.led7seg}, {25'b0, 7'h08});

    // Digit 0 persists through edge 7, then 4-cycle dwells walk 1..6..0
    repeat (4) @(negedge clk);
    check("dwell0_end", {25'b0, bus.trans}, {25'b0, 7'b0111111});
    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      n = (1 + k / 4) % 7;
      check($sformatf("scan_trans_%0d", k), {25'b0, bus.trans}, {25'b0, sel_of(n)});
      check($sformatf("scan_seg_%0d", k), {25'b0, bus.led7seg}, {25'b0, exp_seg(7'(10 + n))});
    end

    // Scroll through all 14 positions and back to 0
    for (int s = 1; s <= 14; s++) begin
      wait_change(p);
      check($sformatf("scroll_pos_%0d", s), {28'b0, p}, 32'(s % 14));
      check_window(int'(p));
    end

    // Pause pulse coincident with a step terminal
    wait_change(p);
    old = p;
    repeat (55) @(posedge clk);
    @(negedge clk);
    bus.pause_btn = 1'b1;
    @(negedge clk);
    bus.pause_btn = 1'b0;
`ifdef MESSAGE_SCROLLER_PAUSE_EN
    changes = 0;
    for (int k = 0; k < 3 * 56; k++) begin
      @(negedge clk);
      if (bus.scroll_pos !== old) changes++;
    end
    check("hold_changes", changes, 0);
    check("hold_pos", {28'b0, bus.scroll_pos}, {28'b0, old});
    bus.pause_btn = 1'b1;
    @(negedge clk);
    bus.pause_btn = 1'b0;
    wait_change(p);
    check("resume_pos", {28'b0, p}, 32'((int'(old) + 1) % 14));
`else
    check("pause_ignored", {28'b0, bus.scroll_pos}, 32'((int'(old) + 1) % 14));
`endif

    // Mode abort at position 5
    n = 0;
    while (bus.scroll_pos !== 4'd5 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("reach_pos5", {31'b0, n < 1000}, 32'd1);
    bus.mode = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_trans", {25'b0, bus.trans}, {25'b0, OFF});
    check("abort_seg",   {25'b0, bus.led7seg}, {25'b0, OFF});

    // Reload with char3 = 62
    exp_chars[3] = 7'd62;
    set_chars();
    bus.mode = 1'b0;
    repeat (2) @(negedge clk);
    check("reload_pos", {28'b0, bus.scroll_pos}, 32'd0);
    check_window(0);

    // Blank code in char2
    exp_chars[2] = 7'd100;
    set_chars();
    bus.mode = 1'b1;
    @(negedge clk);
    bus.mode = 1'b0;
    repeat (2) @(negedge clk);
    check_window(0);

    // Reset mid-operation
    rst = 1'b0;
    @(negedge clk);
    check("midrst_trans", {25'b0, bus.trans}, {25'b0, OFF});
    check("midrst_seg",   {25'b0, bus.led7seg}, {25'b0, OFF});
    check("midrst_pos",   {28'b0, bus.scroll_pos}, 32'd0);
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/message_scroller.md
# message_scroller

- Run-mode display stage: consumes the seven character codes edited in setting mode and scrolls them right-to-left across the 7-digit multiplexed 7-segment display.
- Captures the message when `mode` drops to run, pads it with seven blanks into a 14-position ring, and time-multiplexes the visible 7-position window.
- Shares `trans` and `led7seg` encoding with the setting stage, so the top level muxes the two on `mode`.

## Interface
- `SCAN_DIV`, default 25000: scan counter terminal value; the digit advances every SCAN_DIV+1 cycles.
- `STEP_DIV`, default 12500000: step counter terminal value; the window shifts every STEP_DIV+1 cycles.
- `clk` input 1: system clock; the only clock.
- `rst` input 1: synchronous, active-low reset.
- `mode` input 1: 1 = setting (block idle), 0 = run (block active).
- `char0`..`char6` input 7 each: character codes; 0..62 are valid, 63..127 mean blank.
- `pause_btn` input 1: debounced single-cycle pulse that toggles pause.
- `trans` output 7: active-low one-hot digit select; digit d drives bit 6-d low (digit0 = 7'b0111111).
- `led7seg` output 7: active-low segment pattern for the selected digit.
- `scroll_pos` output 4: current window start, 0..13.

## Operation
- Ring `buf[0..13]`: `buf[0..6]` = `char0..char6`, `buf[7..13]` = 63 (blank).
- FSM:
  - IDLE: entered on reset or whenever `mode`=1. `trans` and `led7seg` = 7'b1111111. Counters held at 0.
  - LOAD: one cycle, entered from IDLE when `mode`=0. Snapshots the chars into the ring, `scroll_pos`=0, scan and step counters=0, scan digit=0. Goes to SCROLL.
  - SCROLL: scan and step counters run. On step terminal, `scroll_pos` wraps 13→0. A `pause_btn` pulse goes to HOLD.
  - HOLD: scan counter runs. Step counter and `scroll_pos` frozen. A `pause_btn` pulse goes to SCROLL.
- From any state, `mode`=1 goes to IDLE on the next edge.
- Digit d shows `buf[(scroll_pos + d) mod 14]`. The index is computed in 4 bits, subtracting 14 when the sum is ≥14.
- Codes ≥63 force `led7seg` = 7'b1111111. Otherwise the segment pattern comes from the character lookup.
- The ring is not updated while running. Char changes take effect only at the next LOAD.

## Timing
- Reset values:
  - Outputs: `trans` = 7'b1111111, `led7seg` = 7'b1111111, `scroll_pos` = 0.
  - Internal: state IDLE, ring all 63, counters 0.
- The character lookup is registered (1-cycle latency). `trans` is delayed one register so digit select and segments change on the same edge.
- Latency from `mode` 1→0 to the first lit digit: LOAD (1) + lookup (1) + output register (1) = 3 cycles.
- Scan: the digit advances 0→6→0 when the scan counter equals SCAN_DIV. The counter then returns to 0.
- Step: `scroll_pos` increments when the step counter equals STEP_DIV.
- Step terminal and pause pulse in the same cycle: the pause wins and `scroll_pos` does not advance. The step counter still clears.
- `mode`=1 mid-scroll: outputs are 7'b1111111 no later than the second edge after the change.
- Reset mid-operation: all reset values apply on the next edge, regardless of state.

## Configuration
- `MESSAGE_SCROLLER_PAUSE_EN`:
  - Defined: HOLD exists and `pause_btn` toggles as above.
  - Undefined: HOLD is not built and `pause_btn` is ignored. The port remains so the top level is unchanged.

## Structure
- Shared package holds:
  - Code constants: `CHAR_BLANK` = 7'd63, `CHAR_MAX` = 7'd62, `MSG_LEN` = 7, `RING_LEN` = 14.
  - `SEG_OFF` = 7'b1111111.
  - FSM state typedef (IDLE, LOAD, SCROLL, HOLD).
- Sub-module: one existing `table_char` instance for the 0..62 code-to-segment lookup, shared by all digits through time-multiplexing. Blank forcing stays in this block.

## Test plan
- Test parameters: SCAN_DIV=3, STEP_DIV=55, clk running.
- Reset check: hold `rst`=0 for 3 cycles with `mode`=0 → `trans`=`led7seg`=7'b1111111 and `scroll_pos`=0. Release → first lit digit at 3 cycles; `trans`=7'b0111111 with the `char0` pattern.
- Scan order: chars 0..6 = codes 10..16 → `trans` walks 0111111, 1011111 … 1111110 with a 4-cycle dwell per digit, and segments match codes 10..16.
- Scroll wrap: run 14 steps → `scroll_pos` goes 0..13 then 0. At `scroll_pos`=7 all seven digits are blank. At `scroll_pos`=10, digits 4..6 show codes 10..12.
- Pause:
  - Pulse `pause_btn` in the same cycle as a step terminal → `scroll_pos` holds for 3×56 cycles.
  - A second pulse → stepping resumes.
  - With the macro undefined → no hold occurs.
- Mode abort and reload: set `mode`=1 at `scroll_pos`=5 → blank within 2 cycles. Change `char3` to 62, then set `mode`=0 → `scroll_pos`=0 and digit 3 shows the code-62 pattern.
- Blank codes: `char2`=100 → digit 2 shows 7'b1111111.
